// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage buffer: occupancy state
// encoding and the default channel width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int PIPE_DEFAULT_WIDTH = 32;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Single-cycle update, no backpressure; asynchronous active-high reset to zero.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_buffer.sv
// Two-entry elastic pipeline buffer (main + skid): one-cycle latency, full throughput,
// in_ready/out_valid decoded from registered state only. Stall/flush counters under PIPE_BUFFER_STATS_EN.
module pipe_buffer
    import pipe_pkg::*;
#(
    parameter int               WIDTH   = PIPE_DEFAULT_WIDTH,
    parameter int               NCH     = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [1:0]           occupancy
`ifdef PIPE_BUFFER_STATS_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [15:0]          flush_cnt
`endif
);

    localparam int DW = NCH * WIDTH;

    pipe_state_e   r_state;
    pipe_state_e   w_state_nxt;
    logic [DW-1:0] r_main;
    logic [DW-1:0] r_skid;

    logic w_in_fire;
    logic w_out_fire;
    logic w_ld_main;
    logic w_main_from_skid;
    logic w_ld_skid;

    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = (r_state != FULL);
    assign occupancy  = r_state;
    assign out_data   = r_main;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ld_main        = 1'b0;
        w_main_from_skid = 1'b0;
        w_ld_skid        = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ONE;
                    w_ld_main   = 1'b1;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_ld_main = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_fire) begin
                    w_state_nxt      = ONE;
                    w_ld_main        = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase
        // Squash overrides every transfer; payload registers simply keep stale data.
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_ld_main        = 1'b0;
            w_main_from_skid = 1'b0;
            w_ld_skid        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= {NCH{RST_VAL}};
            r_skid <= {NCH{RST_VAL}};
        end else begin
            if (w_ld_main) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end
            if (w_ld_skid) begin
                r_skid <= in_data;
            end
        end
    end

`ifdef PIPE_BUFFER_STATS_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = out_valid & ~out_ready;
    assign w_flush_inc = flush & (r_state != EMPTY);

    pipe_sat_counter #(.W(32)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .cnt (stall_cnt)
    );

    pipe_sat_counter #(.W(16)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: doc/pipe_buffer.md
Name: pipe_buffer

Overview:
- Parametrised successor to the fixed IF/ID latch: an elastic pipeline-stage buffer carrying NCH channels of WIDTH bits, e.g. PC + instruction for IF/ID, or more channels for ID/EX.
- Adds a valid/ready handshake, a 2-entry skid so `in_ready` is purely registered, and a synchronous flush for branch squash.
- Sits between any two pipeline stages of the datapath.

Parameters:
- WIDTH, 32, bits per channel
- NCH, 2, number of channels packed into the data buses (channel k = bits [k*WIDTH +: WIDTH])
- RST_VAL, 0, value loaded into every data register on reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash: drop all held entries
- in_valid  in  1  upstream has data
- in_ready  out  1  buffer can accept this cycle
- in_data  in  NCH*WIDTH  upstream payload
- out_valid  out  1  buffer presents data
- out_ready  in  1  downstream accepts this cycle
- out_data  out  NCH*WIDTH  payload from main register
- occupancy  out  2  entries held (0..2)

Behaviour:
- One clock; reset is asynchronous and active-high (`clk`, `rst`).
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Transfer occurs on the rising edge of a fire cycle.
- Storage: main register (drives `out_data`) and skid register. State is EMPTY / ONE / FULL, encoded as `occupancy` 0/1/2.
- Outputs are direct decodes of registered state, with no combinational input-to-output path:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL)
- Transitions when flush = 0:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE:
    - in_fire & out_fire -> ONE, main <= in_data.
    - in_fire & !out_ready -> FULL, skid <= in_data.
    - !in_fire & out_fire -> EMPTY.
    - Otherwise hold.
  - FULL: in_ready = 0. out_fire -> ONE, main <= skid. Otherwise hold.
- Latency: data accepted on edge N appears on `out_data` with `out_valid` = 1 after edge N; minimum one cycle.
- Throughput: one transfer per cycle sustained while `out_ready` = 1.
- Ordering: strict FIFO order, no loss, no duplication.
- Stability: while out_valid & !out_ready, `out_data` holds unchanged.
- Flush:
  - flush = 1 at an edge -> state EMPTY; data registers keep their values (don't-care).
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle counts as delivered; flush wins over everything else.
- Reset:
  - Asynchronous, mid-operation allowed.
  - State EMPTY, main = skid = RST_VAL, out_valid = 0, in_ready = 1, occupancy = 0.
  - Counters (when enabled) = 0.
- Width rules: `out_data` is always exactly NCH*WIDTH; no truncation or extension.

Optional Feature:
- Macro: PIPE_BUFFER_STATS_EN.
- Defined:
  - Adds outputs `stall_cnt` [31:0] and `flush_cnt` [15:0].
  - `stall_cnt` increments each cycle with out_valid & !out_ready.
  - `flush_cnt` increments each cycle flush = 1 while occupancy != 0.
  - Both saturate at all-ones; both reset to 0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Shared package `pipe_pkg`: state typedef (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2) and constant for the default WIDTH 32.
- Natural sub-module: `pipe_sat_counter` (parametrised width, inc, async reset), instantiated twice under PIPE_BUFFER_STATS_EN.

Test Plan:
- Reset then pass-through: rst 1 -> 0, out_ready = 1, in_data = {32'h4, 32'h1}, {32'h8, 32'h2}, {32'hC, 32'h3} on consecutive cycles -> same words on out_data one cycle later each; out_valid continuous; occupancy stays 1.
- Backpressure: out_ready = 0, send A = {32'h10, 32'hAA}, B = {32'h14, 32'hBB} -> occupancy 2, in_ready = 0, out_data holds A. Then out_ready = 1 -> A, then B, then out_valid = 0.
- Flush: FULL with A, B; flush = 1 together with in_valid (C) -> next cycle occupancy 0, out_valid 0; C never appears.
- Async reset mid-operation: assert rst between edges while FULL -> out_valid, occupancy and out_data (RST_VAL) change immediately without a clock edge; in_ready = 1.
- Parameter sweep: WIDTH = 8, NCH = 4, random valid/ready at 50% for 1000 cycles -> scoreboard shows in-order, lossless delivery; in_ready never 1 while occupancy = 2.
- PIPE_BUFFER_STATS_EN: hold out_ready = 0 for 5 cycles with occupancy 1, then flush once -> stall_cnt = 5, flush_cnt = 1.
